// File: rtl/icache_responder.sv
// ---------------------------------------------------------------------------
// icache_responder
//   Direct-mapped, read-only instruction cache sitting between ifetch and the
//   shared memory bus. Hits return the 64-bit line combinationally from the
//   registered arrays; a miss issues one tagged BUS_LOAD and fills the line
//   when the matching tag comes back. Only one miss is outstanding at a time.
//
// Ports
//   clock                   system clock
//   reset                   asynchronous active-high reset
//   proc2Icache_addr        fetch address (bits [2:0] ignored)
//   Icache2proc_data        line data at the indexed set
//   Icache2proc_data_valid  high when Icache2proc_data is a hit this cycle
//   proc2mem_command        BUS_NONE=0 / BUS_LOAD=1
//   proc2mem_addr           line-aligned load address, 0 when not loading
//   mem2proc_response       nonzero = load accepted with that tag, 0 = retry
//   mem2proc_data           returning line data
//   mem2proc_tag            tag of returning data, 0 = nothing returning
//   miss_busy               high while a miss is being serviced
//
// Configuration
//   `XLEN                   address width (defaults to 32 when undefined)
//   ICACHE_FILL_BYPASS_EN   when defined, the returning line is forwarded to
//                           the fetch stage in the fill cycle if the current
//                           address matches the line being filled
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module icache_responder #(
  parameter int CACHE_LINES = 32,
  parameter int IDX_BITS    = $clog2(CACHE_LINES),
  parameter int TAG_BITS    = `XLEN - 3 - IDX_BITS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [`XLEN-1:0]  proc2Icache_addr,
  output logic [63:0]       Icache2proc_data,
  output logic              Icache2proc_data_valid,
  output logic [1:0]        proc2mem_command,
  output logic [`XLEN-1:0]  proc2mem_addr,
  input  logic [3:0]        mem2proc_response,
  input  logic [63:0]       mem2proc_data,
  input  logic [3:0]        mem2proc_tag,
  output logic              miss_busy
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Address split
  logic [IDX_BITS-1:0] cur_idx;
  logic [TAG_BITS-1:0] cur_tag;
  logic [2:0]          unused_offset;

  assign cur_idx       = proc2Icache_addr[IDX_BITS+2:3];
  assign cur_tag       = proc2Icache_addr[`XLEN-1:IDX_BITS+3];
  assign unused_offset = proc2Icache_addr[2:0];

  // Line storage: only the valid bits need reset
  logic [CACHE_LINES-1:0] valid;
  logic [TAG_BITS-1:0]    tags [CACHE_LINES];
  logic [63:0]            data [CACHE_LINES];

  // Miss bookkeeping
  state_t              state;
  logic [IDX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0] miss_tag;
  logic [3:0]          mem_tag;

  logic hit;
  logic fill;

  assign hit  = valid[cur_idx] && (tags[cur_idx] == cur_tag);
  // mem_tag is always a nonzero accepted tag while in WAIT, so an idle bus
  // (tag 0) can never complete a fill.
  assign fill = (state == WAIT) && (mem2proc_tag == mem_tag);

  // Fetch-side response
  always_comb begin
    Icache2proc_data       = data[cur_idx];
    Icache2proc_data_valid = hit;
`ifdef ICACHE_FILL_BYPASS_EN
    if (fill && (cur_idx == miss_idx) && (cur_tag == miss_tag)) begin
      Icache2proc_data       = mem2proc_data;
      Icache2proc_data_valid = 1'b1;
    end
`endif
  end

  // Miss FSM with registered bus outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      miss_idx         <= '0;
      miss_tag         <= '0;
      mem_tag          <= '0;
      valid            <= '0;
      proc2mem_command <= BUS_NONE;
      proc2mem_addr    <= '0;
      miss_busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            miss_idx         <= cur_idx;
            miss_tag         <= cur_tag;
            state            <= REQ;
            proc2mem_command <= BUS_LOAD;
            proc2mem_addr    <= {cur_tag, cur_idx, 3'b000};
            miss_busy        <= 1'b1;
          end
        end
        REQ: begin
          // A rejected load simply stays in REQ and is re-presented.
          if (mem2proc_response != 4'd0) begin
            mem_tag          <= mem2proc_response;
            state            <= WAIT;
            proc2mem_command <= BUS_NONE;
            proc2mem_addr    <= '0;
          end
        end
        WAIT: begin
          if (fill) begin
            valid[miss_idx] <= 1'b1;
            state           <= IDLE;
            miss_busy       <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          proc2mem_command <= BUS_NONE;
          proc2mem_addr    <= '0;
          miss_busy        <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data arrays; a fill always lands in miss_idx even after a redirect
  always_ff @(posedge clock) begin
    if (fill) begin
      tags[miss_idx] <= miss_tag;
      data[miss_idx] <= mem2proc_data;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
`ifndef XLEN
`define XLEN 32
`endif

module tb_icache_responder;

  localparam int LINES = 32;
  localparam int IDXB  = 5;
  localparam int TAGB  = `XLEN - 3 - IDXB;
`ifdef ICACHE_FILL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [`XLEN-1:0]  addr  = '0;
  logic [63:0]       rdata;
  logic              rvalid;
  logic [1:0]        cmd;
  logic [`XLEN-1:0]  maddr;
  logic [3:0]        resp  = '0;
  logic [63:0]       mdata = '0;
  logic [3:0]        mtag  = '0;
  logic              busy;

  always #5 clock = ~clock;

  icache_responder #(.CACHE_LINES(LINES)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .proc2Icache_addr      (addr),
    .Icache2proc_data      (rdata),
    .Icache2proc_data_valid(rvalid),
    .proc2mem_command      (cmd),
    .proc2mem_addr         (maddr),
    .mem2proc_response     (resp),
    .mem2proc_data         (mdata),
    .mem2proc_tag          (mtag),
    .miss_busy             (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cache contents as plain arrays plus one record for the outstanding miss.
  bit              mv [LINES];
  bit              mw [LINES];
  logic [TAGB-1:0] mt [LINES];
  logic [63:0]     md [LINES];

  bit              m_active = 1'b0;  // a miss is being serviced
  bit              m_acc    = 1'b0;  // its load has been accepted by the bus
  int unsigned     m_idx    = 0;
  logic [TAGB-1:0] m_tag    = '0;
  logic [3:0]      m_btag   = '0;

  function automatic int unsigned idx_of(input logic [`XLEN-1:0] a);
    return (a >> 3) % LINES;
  endfunction

  function automatic logic [TAGB-1:0] tag_of(input logic [`XLEN-1:0] a);
    return TAGB'(a >> (3 + IDXB));
  endfunction

  function automatic bit m_hit(input logic [`XLEN-1:0] a);
    return mv[idx_of(a)] && (mt[idx_of(a)] == tag_of(a));
  endfunction

  function automatic bit bypass_now();
    return BYP && m_active && m_acc && (mtag == m_btag) &&
           (idx_of(addr) == m_idx) && (tag_of(addr) == m_tag);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      foreach (mv[i]) mv[i] = 1'b0;
      m_active = 1'b0;
      m_acc    = 1'b0;
    end else if (!m_active) begin
      if (!m_hit(addr)) begin
        m_active = 1'b1;
        m_acc    = 1'b0;
        m_idx    = idx_of(addr);
        m_tag    = tag_of(addr);
      end
    end else if (!m_acc) begin
      if (resp != 4'd0) begin
        m_acc  = 1'b1;
        m_btag = resp;
      end
    end else if (mtag == m_btag) begin
      mv[m_idx] = 1'b1;
      mw[m_idx] = 1'b1;
      mt[m_idx] = m_tag;
      md[m_idx] = mdata;
      m_active  = 1'b0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    int unsigned      i;
    bit               byp;
    bit               loading;
    logic [`XLEN-1:0] ea;
    if (!reset) begin
      i       = idx_of(addr);
      byp     = bypass_now();
      loading = m_active && !m_acc;
      ea      = loading ? {m_tag, m_idx[IDXB-1:0], 3'b000} : '0;
      chk("data_valid", rvalid, m_hit(addr) || byp);
      if (byp)        chk("data_bypass", rdata, mdata);
      else if (mw[i]) chk("data", rdata, md[i]);
      chk("command", cmd, loading ? 64'd1 : 64'd0);
      chk("mem_addr", maddr, ea);
      chk("miss_busy", busy, m_active);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Full miss with a single accepted load, checking literal timing points
  task automatic miss_fill(input logic [`XLEN-1:0] a, input logic [3:0] rt, input logic [63:0] d);
    logic [`XLEN-1:0] line;
    line = a & ~`XLEN'(7);
    addr = a;
    #1 chk("mf_miss_valid", rvalid, 0);
    cyc();
    chk("mf_req_cmd", cmd, 1);
    chk("mf_req_addr", maddr, line);
    resp = rt;
    cyc();
    resp = '0;
    chk("mf_wait_cmd", cmd, 0);
    chk("mf_wait_busy", busy, 1);
    mtag  = rt;
    mdata = d;
    #1 chk("mf_return_valid", rvalid, BYP);
    cyc();
    mtag  = '0;
    mdata = {$urandom(), $urandom()};
    #1;
    chk("mf_after_valid", rvalid, 1);
    chk("mf_after_data", rdata, d);
    chk("mf_after_busy", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          out_pending;
    int          dly;
    logic [3:0]  out_tag;
    logic [3:0]  r;

    #1 reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    addr  = '0;
    #1;
    chk("reset_valid", rvalid, 0);
    chk("reset_cmd", cmd, 0);
    chk("reset_addr", maddr, 0);
    chk("reset_busy", busy, 0);

    // First fill of line 0
    miss_fill('h0, 4'd3, 64'h1111_2222_3333_4444);

    // Hit on same line with a different offset
    cyc();
    addr = 'h4;
    #1;
    chk("hit_valid", rvalid, 1);
    chk("hit_data", rdata, 64'h1111_2222_3333_4444);
    chk("hit_cmd", cmd, 0);

    // Bus rejection, then conflicting fill of index 0 with tag 1
    cyc();
    addr = 'h100;
    #1 chk("rej_miss_valid", rvalid, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rej_cmd", cmd, 1);
      chk("rej_addr", maddr, 'h100);
    end
    resp = 4'd5;
    cyc();
    resp = '0;
    chk("rej_wait_cmd", cmd, 0);
    chk("rej_wait_busy", busy, 1);
    mtag  = 4'd2;
    mdata = 64'hDEAD_BEEF_DEAD_BEEF;
    cyc();
    mtag = '0;
    #1;
    chk("rej_ignore_valid", rvalid, 0);
    chk("rej_ignore_busy", busy, 1);
    mtag  = 4'd5;
    mdata = 64'h0101_0202_0303_0404;
    cyc();
    mtag = '0;
    #1;
    chk("evict_new_valid", rvalid, 1);
    chk("evict_new_data", rdata, 64'h0101_0202_0303_0404);

    // Line 0x000 was evicted and must be fetched again
    cyc();
    miss_fill('h0, 4'd7, 64'hAAAA_0000_BBBB_0000);

    // Redirect during a miss, then reset mid-WAIT
    cyc();
    addr = 'h40;
    #1 chk("rd_miss_valid", rvalid, 0);
    cyc();
    chk("rd_req_addr", maddr, 'h40);
    resp = 4'd1;
    cyc();
    resp = '0;
    addr = 'h80;
    chk("rd_wait_busy", busy, 1);
    mtag  = 4'd1;
    mdata = 64'h5555_6666_7777_8888;
    #1 chk("rd_fill_valid", rvalid, 0);
    cyc();
    mtag = '0;
    #1;
    chk("rd_after_valid", rvalid, 0);
    chk("rd_after_busy", busy, 0);
    cyc();
    chk("rd_new_cmd", cmd, 1);
    chk("rd_new_addr", maddr, 'h80);
    addr = 'h40;
    #1;
    chk("rd_old_hit_valid", rvalid, 1);
    chk("rd_old_hit_data", rdata, 64'h5555_6666_7777_8888);
    resp = 4'd2;
    cyc();
    resp = '0;
    chk("rs_wait_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("rs_valid", rvalid, 0);
    chk("rs_cmd", cmd, 0);
    chk("rs_addr", maddr, 0);
    chk("rs_busy", busy, 0);
    cyc();
    reset = 1'b0;
    mtag  = 4'd2;
    mdata = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    chk("rs_late_valid", rvalid, 0);
    chk("rs_late_cmd", cmd, 0);
    cyc();
    mtag = '0;
    chk("rs_remiss_cmd", cmd, 1);
    chk("rs_remiss_addr", maddr, 'h40);
    resp = 4'd4;
    cyc();
    resp  = '0;
    mtag  = 4'd4;
    mdata = 64'h4040_4040_4040_4040;
    cyc();
    mtag = '0;
    #1 chk("rs_refill_data", rdata, 64'h4040_4040_4040_4040);

    // Fill cycle visibility (same cycle with bypass, one cycle later without)
    cyc();
    miss_fill('h200, 4'd9, 64'h0200_0200_0200_0200);

    // Randomized traffic against the model
    out_pending = 1'b0;
    dly         = 0;
    out_tag     = '0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if ($urandom_range(0, 3) == 0)
        addr = (`XLEN'($urandom_range(0, 3)) << 8) |
               (`XLEN'($urandom_range(0, 31)) << 3) |
               `XLEN'($urandom_range(0, 7));
      // Returns first, so a load is never answered in its own accept cycle
      mtag  = '0;
      mdata = {$urandom(), $urandom()};
      if (out_pending && dly == 0) begin
        mtag        = out_tag;
        out_pending = 1'b0;
      end else begin
        if (out_pending) dly--;
        if ($urandom_range(0, 7) == 0) mtag = 4'($urandom_range(1, 15));
      end
      resp = '0;
      if (cmd == 2'd1) begin
        if ($urandom_range(0, 1) == 1) begin
          r           = 4'($urandom_range(1, 15));
          resp        = r;
          out_pending = 1'b1;
          out_tag     = r;
          dly         = $urandom_range(0, 4);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        resp = 4'($urandom_range(1, 15));
      end
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #1;
        chk("rnd_rs_valid", rvalid, 0);
        chk("rnd_rs_cmd", cmd, 0);
        chk("rnd_rs_busy", busy, 0);
        cyc();
        reset       = 1'b0;
        out_pending = 1'b0;
      end
    end

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
